mem_dump_unit: RTL and testbench
================================

Name: mem_dump_unit

Overview:
- Post-run memory readout engine for pipelined_processor. It is the reader at the other end of the data-memory path the program writes through.
- When the processor is HALTED, it walks a requested address range of the unified memory and streams each word out over a valid/ready port, to a bench monitor or host link.
- It replaces hierarchical mem[] peeks with a synthesizable result-extraction path.

Parameters:
ADDR_W, 10, memory word-address width (1024-word mem).
DATA_W, 32, memory word width.

Ports:
clk1  input  1  single clock, same phase-1 clock as the processor core.
rst  input  1  synchronous active-high reset; sampled on rising clk1.
halted  input  1  processor HALTED flag; a dump is legal only while it is 1.
start  input  1  one-cycle request pulse; sampled only in IDLE.
start_addr  input  ADDR_W  first word address, inclusive.
end_addr  input  ADDR_W  last word address, inclusive.
mem_rd_en  output  1  memory read strobe.
mem_rd_addr  output  ADDR_W  memory read address.
mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
out_valid  output  1  out_addr/out_data/out_last valid.
out_ready  input  1  sink accepts the beat when out_valid & out_ready.
out_addr  output  ADDR_W  address of the streamed word.
out_data  output  DATA_W  streamed word.
out_last  output  1  final beat of the dump.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the final beat is accepted.
err  output  1  one-cycle pulse on a rejected or aborted request.

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_rd_en, mem_rd_addr, out_valid, out_addr, out_data, out_last, busy, done, err. Reset mid-dump abandons it silently; no done, no err.
- FSM states: IDLE, REQ, WAIT, OUT, FIN.
- IDLE:
  - start & halted & start_addr<=end_addr: latch cur=start_addr and end, go to REQ.
  - start & (!halted | start_addr>end_addr): err=1 for one cycle, stay in IDLE.
- REQ: mem_rd_en=1, mem_rd_addr=cur for exactly one cycle, then go to WAIT.
- WAIT: register mem_rd_data into out_data and set out_addr=cur. Assert out_valid from the next cycle. out_last=(cur==end). Go to OUT.
- OUT:
  - Hold out_valid, out_addr, out_data and out_last stable until out_ready.
  - On handshake with cur==end: go to FIN.
  - On handshake otherwise: cur=cur+1, go to REQ.
  - out_ready already high: a beat is produced every 3 cycles (REQ, WAIT, OUT).
- FIN: done=1 for one cycle, return to IDLE.
- Abort: halted falling in REQ, WAIT or OUT gives IDLE next cycle with out_valid=0 and err=1 for one cycle. A handshake in that same cycle still counts as delivered.
- Wrap-around: end_addr=2^ADDR_W-1 is legal. The increment never executes past end, because the compare happens before the increment.
- start_addr==end_addr produces a single beat with out_last=1.
- start is ignored while busy. start and halted falling together in IDLE gives err.

Optional Feature:
MEM_DUMP_CHECKSUM_EN:
- Defined:
  - A 32-bit modulo-2^32 sum of every streamed word accumulates during the dump.
  - After the last data beat, one extra beat is sent with out_addr=end and out_data=sum.
  - out_last moves to that checksum beat; done follows its handshake.
  - An abort discards the sum.
- Undefined: no accumulator and no extra beat; out_last marks the last data word.

Decomposition:
- Shared include mem_dump_defs.vh:
  - State encodings IDLE=3'd0, REQ=3'd1, WAIT=3'd2, OUT=3'd3, FIN=3'd4, CSUM=3'd5.
  - Default ADDR_W and DATA_W.
- Sub-module mem_dump_csum: accumulator with clr/en/sum ports. Instantiated only under MEM_DUMP_CHECKSUM_EN.

Test Plan:
- Run the load/add/store program (mem[120]=85), wait for halted, start 120..121, out_ready=1. Required: beats (120,85,last=0) then (121,130,last=1), each spaced 3 cycles apart, then a done pulse.
- start with halted=0. Required: err pulse, busy stays 0, no mem_rd_en.
- start_addr=5, end_addr=4. Required: err pulse, no beats.
- 1-word dump of 1023..1023 with out_ready held low for 4 cycles. Required: out_valid and out_data stay stable, one beat with last=1 after out_ready rises, no address wrap.
- Drop halted during the second of 3 beats. Required: out_valid=0 and err=1 next cycle; an immediate restart works.
- With MEM_DUMP_CHECKSUM_EN, dump 120..121. Required: third beat out_data=215 with last=1, then done.

Source files
------------

// File: rtl/mem_dump_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_dump_unit_pkg
// Shared definitions for the post-run memory readout engine: default widths,
// FSM state encoding and a small state-classification helper.
// -----------------------------------------------------------------------------
package mem_dump_unit_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4,
    ST_CSUM = 3'd5
  } state_e;

  // States in which a falling halted flag aborts the dump.
  function automatic logic is_abortable(state_e s);
    return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_OUT) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/mem_dump_csum.sv
// -----------------------------------------------------------------------------
// mem_dump_csum
// Modulo-2^W running sum of the words streamed by mem_dump_unit. Only
// instantiated when MEM_DUMP_CHECKSUM_EN is defined.
// Ports:
//   clk1 - clock            rst - synchronous active-high reset
//   clr  - clear the sum    en  - add 'add' to the sum (clr has priority)
//   add  - word to add      sum - current sum
// -----------------------------------------------------------------------------
module mem_dump_csum #(
  parameter int W = 32
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + add;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_dump_unit.sv
// -----------------------------------------------------------------------------
// mem_dump_unit
// Reads a word-address range of the unified memory while the processor is
// halted and streams each word out on a valid/ready port.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN - appends one extra beat
// (out_addr=end, out_data=sum of all streamed words) carrying out_last.
// Ports:
//   clk1, rst                 - clock, synchronous active-high reset
//   halted                    - processor halted flag; dump legal only when 1
//   start, start_addr, end_addr - request pulse and inclusive address range
//   mem_rd_en, mem_rd_addr    - memory read strobe and address
//   mem_rd_data               - read data, valid one cycle after mem_rd_en
//   out_valid, out_ready      - stream handshake
//   out_addr, out_data, out_last - stream beat contents
//   busy, done, err           - status: not idle / dump complete / rejected or aborted
// -----------------------------------------------------------------------------
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;

  logic accept, reject, abort, hs, at_end, beat_state;

  assign accept     = (state_q == ST_IDLE) && start && halted && (start_addr <= end_addr);
  assign reject     = (state_q == ST_IDLE) && start && !(halted && (start_addr <= end_addr));
  assign abort      = is_abortable(state_q) && !halted;
  assign beat_state = (state_q == ST_OUT) || (state_q == ST_CSUM);
  assign hs         = beat_state && out_ready;
  // Compared before any increment, so a range ending at the top address
  // never wraps cur.
  assign at_end     = (cur_q == end_q);

  logic [DATA_W-1:0] csum_sum;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;

  mem_dump_csum #(
    .W(DATA_W)
  ) u_csum (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (accept || abort),
    .en   ((state_q == ST_OUT) && hs),
    .add  (out_data_q),
    .sum  (csum_sum)
  );
`else
  localparam bit CsumEn = 1'b0;

  assign csum_sum = '0;
`endif

  // State and datapath registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; a falling halted flag overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_OUT;
      ST_OUT: begin
        if (hs) begin
          if (!at_end)     state_d = ST_REQ;
          else if (CsumEn) state_d = ST_CSUM;
          else             state_d = ST_FIN;
        end
      end
      ST_CSUM: if (hs) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath next values
  always_comb begin
    cur_d      = cur_q;
    end_d      = end_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    err_d      = reject || abort;
    if (accept) begin
      cur_d = start_addr;
      end_d = end_addr;
    end
    if (state_q == ST_WAIT) begin
      out_addr_d = cur_q;
      out_data_d = mem_rd_data;
      // With the checksum beat present, no data beat is the last one.
      out_last_d = at_end && !CsumEn;
    end
    if ((state_q == ST_OUT) && hs && !at_end && !abort) begin
      cur_d = cur_q + ADDR_W'(1);
    end
  end

  // Outputs
  always_comb begin
    mem_rd_en   = (state_q == ST_REQ);
    mem_rd_addr = (state_q == ST_REQ) ? cur_q : '0;
    out_valid   = beat_state;
    out_addr    = out_addr_q;
    out_data    = (state_q == ST_CSUM) ? csum_sum : out_data_q;
    out_last    = (state_q == ST_CSUM) ? 1'b1 : out_last_q;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FIN);
    err         = err_q;
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_unit
// Self-checking bench for mem_dump_unit: a bench-side memory answers read
// strobes, a table of dump requests plus random requests are run, and every
// accepted beat is compared with the address/word list computed directly
// from the requested range and the memory contents.
// -----------------------------------------------------------------------------
module tb_mem_dump_unit;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst, halted, start;
  logic [AW-1:0] start_addr, end_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last, busy, done, err;

  always #5 clk1 = ~clk1;

  mem_dump_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .halted      (halted),
    .start       (start),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Bench memory: synchronous read, data one cycle after the strobe.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observed results of one run
  int rb_addr[$], rb_data[$], rb_last[$], rb_cyc[$];
  int r_err, r_done, r_rd, r_unstable;
  bit r_busy_seen, r_timeout, r_abort_bad;

  // Expected beat list
  int ex_addr[$], ex_data[$], ex_last[$];

  function automatic void build_model(input int sa, input int ea, input bit ok);
    logic [DW-1:0] sum;
    sum = '0;
    ex_addr.delete(); ex_data.delete(); ex_last.delete();
    if (!ok) return;
    for (int a = sa; a <= ea; a++) begin
      ex_addr.push_back(a);
      ex_data.push_back(int'(mem[a]));
      ex_last.push_back(a == ea);
      sum = sum + mem[a];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    ex_last[ex_last.size()-1] = 0;
    ex_addr.push_back(ea);
    ex_data.push_back(int'(sum));
    ex_last.push_back(1);
`endif
  endfunction

  task automatic run_dump(input int sa, input int ea, input bit hlt, input int hold_low,
                          input int pct, input int abort_beat, input bit junk);
    int low_cnt = 0;
    bit abort_pend = 0;
    bit prev_hold = 0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic pl;
    pa = '0; pd = '0; pl = 1'b0;
    rb_addr.delete(); rb_data.delete(); rb_last.delete(); rb_cyc.delete();
    r_err = 0; r_done = 0; r_rd = 0; r_unstable = 0;
    r_busy_seen = 0; r_timeout = 1; r_abort_bad = 0;
    start_addr = sa[AW-1:0];
    end_addr   = ea[AW-1:0];
    halted     = hlt;
    start      = 1'b1;
    out_ready  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk1); #1;
      start = 1'b0;
      if (err) r_err++;
      if (done) r_done++;
      if (mem_rd_en) r_rd++;
      if (busy) r_busy_seen = 1;
      if (abort_pend) begin
        if (out_valid || !err) r_abort_bad = 1;
        abort_pend = 0;
      end
      if (prev_hold && out_valid &&
          (out_addr !== pa || out_data !== pd || out_last !== pl)) r_unstable++;
      if (!busy && (r_done > 0 || r_err > 0 || cyc >= 2)) begin
        r_timeout = 0;
        break;
      end
      if (out_valid) begin
        if (low_cnt < hold_low) begin
          out_ready = 1'b0;
          low_cnt++;
        end else begin
          out_ready = ($urandom_range(0, 99) < pct);
        end
      end else begin
        out_ready = $urandom_range(0, 1) == 1;
      end
      if (out_valid && abort_beat >= 0 && rb_addr.size() == abort_beat && halted) begin
        halted = 1'b0;
        abort_pend = 1;
      end
      if (junk && busy && $urandom_range(0, 3) == 0) begin
        start      = 1'b1;
        start_addr = AW'($urandom);
        end_addr   = AW'($urandom);
      end
      if (out_valid && out_ready) begin
        rb_addr.push_back(int'(out_addr));
        rb_data.push_back(int'(out_data));
        rb_last.push_back(int'(out_last));
        rb_cyc.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      pa = out_addr; pd = out_data; pl = out_last;
    end
    start = 1'b0;
  endtask

  task automatic compare_run(input string tag, input int cap, input int exp_err,
                             input int exp_done, input int exp_rd);
    int n;
    n = ex_addr.size();
    if (cap >= 0 && cap < n) n = cap;
    check({tag, " timeout"}, r_timeout, 0);
    check({tag, " beats"}, rb_addr.size(), n);
    for (int i = 0; i < n && i < rb_addr.size(); i++) begin
      check($sformatf("%s beat%0d addr", tag, i), rb_addr[i], ex_addr[i]);
      check($sformatf("%s beat%0d data", tag, i), rb_data[i], ex_data[i]);
      check($sformatf("%s beat%0d last", tag, i), rb_last[i], ex_last[i]);
    end
    check({tag, " err pulses"}, r_err, exp_err);
    check({tag, " done pulses"}, r_done, exp_done);
    check({tag, " reads"}, r_rd, exp_rd);
    check({tag, " unstable"}, r_unstable, 0);
    check({tag, " abort"}, r_abort_bad, 0);
  endtask

  typedef struct {
    int sa; int ea; bit hlt; int hold_low; int pct; int abort_beat; int exp_err; int exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int cap, exp_rd, sa, ea, e_cnt, d_cnt;

    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
    mem[120] = 32'd85;
    mem[121] = 32'd130;
    mem_rd_data = '0;

    //            sa    ea   hlt hold pct abort err done
    vecs[0] = '{ 120,  121, 1,  0,  100, -1,   0,  1 };
    vecs[1] = '{ 0,    0,   0,  0,  100, -1,   1,  0 };
    vecs[2] = '{ 5,    4,   1,  0,  100, -1,   1,  0 };
    vecs[3] = '{ 1023, 1023,1,  4,  100, -1,   0,  1 };
    vecs[4] = '{ 10,   12,  1,  0,  100,  1,   1,  0 };
    vecs[5] = '{ 10,   12,  1,  0,  100, -1,   0,  1 };
    vecs[6] = '{ 1020, 1023,1,  0,  50,  -1,   0,  1 };
    vecs[7] = '{ 0,    3,   1,  2,  70,  -1,   0,  1 };

    rst = 1'b1; halted = 1'b0; start = 1'b0; out_ready = 1'b0;
    start_addr = '0; end_addr = '0;
    repeat (2) @(posedge clk1);
    #1;
    check("reset mem_rd", {mem_rd_en, mem_rd_addr}, 0);
    check("reset out", {out_valid, out_addr, out_data, out_last}, 0);
    check("reset status", {busy, done, err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ok  = vecs[i].hlt && (vecs[i].sa <= vecs[i].ea);
      cap = vecs[i].abort_beat >= 0 ? vecs[i].abort_beat + 1 : -1;
      exp_rd = !ok ? 0 : (cap >= 0 ? cap : vecs[i].ea - vecs[i].sa + 1);
      build_model(vecs[i].sa, vecs[i].ea, ok);
      run_dump(vecs[i].sa, vecs[i].ea, vecs[i].hlt, vecs[i].hold_low, vecs[i].pct,
               vecs[i].abort_beat, 1'b0);
      compare_run($sformatf("vec%0d", i), cap, vecs[i].exp_err, vecs[i].exp_done, exp_rd);
      if (!ok) check($sformatf("vec%0d busy", i), r_busy_seen, 0);
      if (i == 0 && rb_cyc.size() >= 2) begin
        check("vec0 spacing", rb_cyc[1] - rb_cyc[0], 3);
        check("vec0 word0", rb_data[0], 85);
        check("vec0 word1", rb_data[1], 130);
`ifdef MEM_DUMP_CHECKSUM_EN
        if (rb_data.size() >= 3) check("vec0 checksum", rb_data[2], 215);
        else check("vec0 checksum beat", rb_data.size(), 3);
`endif
      end
    end

    // Reset in the middle of a dump: abandoned silently.
    start_addr = AW'(200); end_addr = AW'(210); halted = 1'b1; start = 1'b1; out_ready = 1'b0;
    @(posedge clk1); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk1); #1; end
    check("middump busy before reset", busy, 1);
    rst = 1'b1;
    @(posedge clk1); #1;
    check("middump reset out", {out_valid, out_addr, out_data, out_last}, 0);
    check("middump reset status", {mem_rd_en, busy, done, err}, 0);
    rst = 1'b0;
    e_cnt = 0; d_cnt = 0;
    repeat (8) begin
      @(posedge clk1); #1;
      e_cnt += int'(err);
      d_cnt += int'(done);
    end
    check("middump err", e_cnt, 0);
    check("middump done", d_cnt, 0);

    // Random ranges, random back-pressure, stray start pulses while busy.
    for (int k = 0; k < 15; k++) begin
      sa = $urandom_range(0, 1023);
      ea = sa + $urandom_range(0, 4);
      if (ea > 1023) ea = 1023;
      build_model(sa, ea, 1'b1);
      run_dump(sa, ea, 1'b1, 0, $urandom_range(30, 100), -1, 1'b1);
      compare_run($sformatf("rnd%0d", k), -1, 0, 1, ea - sa + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
